// File: rtl/myo_spi_slave.sv
// -----------------------------------------------------------------------------
// myo_spi_slave
//
// SPI mode-0 responder that stands in for one motor board on the myocontrol
// link. sck/mosi/ss_n are oversampled in the system clock domain, so the
// system clock has to run at least 8x faster than sck.
//
// A frame is WORDS_PER_FRAME words of WORD_BITS bits, MSB first. Each
// received word is presented on rx_word/rx_index with a one-cycle rx_valid
// strobe. While the master clocks in commands, the slave returns the status
// words captured from tx_frame at the moment of select.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   sck          SPI clock from master (asynchronous, idle low)
//   mosi         master-out data (asynchronous)
//   ss_n         active-low slave select (asynchronous)
//   miso         slave-out data; 0 whenever no frame is being served
//   tx_frame     status words to return; word 0 in the top bits
//   rx_word      last complete received word
//   rx_index     position of rx_word within the frame
//   rx_valid     one-cycle strobe qualifying rx_word/rx_index
//   frame_done   one-cycle strobe at deselect
//   frame_ok     verdict of the last frame, held until the next frame_done
//   error_count  saturating count of bad frames
// -----------------------------------------------------------------------------
module myo_spi_slave #(
  parameter int WORD_BITS       = 16,
  parameter int WORDS_PER_FRAME = 12,
  parameter int IDX_W           = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 sck,
  input  logic                                 mosi,
  input  logic                                 ss_n,
  output logic                                 miso,
  input  logic [WORDS_PER_FRAME*WORD_BITS-1:0] tx_frame,
  output logic [WORD_BITS-1:0]                 rx_word,
  output logic [IDX_W-1:0]                     rx_index,
  output logic                                 rx_valid,
  output logic                                 frame_done,
  output logic                                 frame_ok,
  output logic [15:0]                          error_count
);

  localparam int FRAME_W = WORDS_PER_FRAME * WORD_BITS;
  localparam int BC_W    = $clog2(WORD_BITS + 1);
  // One spare bit so the word counter can hold WORDS_PER_FRAME itself
  // even when WORDS_PER_FRAME == 2**IDX_W.
  localparam int WC_W    = IDX_W + 1;

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_BITS - 1);
  localparam logic [WC_W-1:0] WORD_END = WC_W'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {
    ST_ARMWAIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_OVERRUN
  } state_t;

  // Select word idx of a frame image; indices past the frame read as zero.
  function automatic logic [WORD_BITS-1:0] frame_word(
    input logic [FRAME_W-1:0] f,
    input logic [WC_W-1:0]    idx
  );
    frame_word = '0;
    for (int k = 0; k < WORDS_PER_FRAME; k++) begin
      if (idx == WC_W'(k)) begin
        frame_word = f[(WORDS_PER_FRAME-1-k)*WORD_BITS +: WORD_BITS];
      end
    end
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers (not reset: they must keep tracking the pins while
  // reset is held so ARMWAIT sees the true select level on release)
  // ---------------------------------------------------------------------------
  logic sck_q1, sck_q2, sck_q3;
  logic ss_q1, ss_q2, ss_q3;
  logic mosi_q1, mosi_q2;

  always_ff @(posedge clock) begin
    sck_q1  <= sck;
    sck_q2  <= sck_q1;
    sck_q3  <= sck_q2;
    ss_q1   <= ss_n;
    ss_q2   <= ss_q1;
    ss_q3   <= ss_q2;
    mosi_q1 <= mosi;
    mosi_q2 <= mosi_q1;
  end

  logic s_ss_n, s_mosi;
  logic rise, fall, sel, desel;

  assign s_ss_n = ss_q2;
  assign s_mosi = mosi_q2;
  assign rise   =  sck_q2 & ~sck_q3;
  assign fall   = ~sck_q2 &  sck_q3;
  assign sel    = ~ss_q2  &  ss_q3;
  assign desel  =  ss_q2  & ~ss_q3;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [WORD_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_BITS-1:0] rx_sr_q, rx_sr_d;
  logic                 miso_q, miso_d;
  logic [WORD_BITS-1:0] rx_word_q, rx_word_d;
  logic [IDX_W-1:0]     rx_index_q, rx_index_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_ok_q, frame_ok_d;
  logic [15:0]          error_count_q, error_count_d;
  logic                 good_frame;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    frame_d       = frame_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    miso_d        = 1'b0;
    rx_word_d     = rx_word_q;
    rx_index_d    = rx_index_q;
    rx_valid_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    error_count_d = error_count_q;
    good_frame    = 1'b0;

    case (state_q)
      ST_ARMWAIT: begin
        // Whatever frame was running across reset is dropped silently.
        if (s_ss_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (sel) begin
          frame_d    = tx_frame;
          tx_sr_d    = frame_word(tx_frame, '0);
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          miso_d     = tx_sr_d[WORD_BITS-1];
          state_d    = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        miso_d = miso_q;
        if (rise) begin
          if (word_cnt_q == WORD_END) begin
            // Any bit beyond the last word spoils the frame.
            state_d = ST_OVERRUN;
            miso_d  = 1'b0;
          end else begin
            rx_sr_d    = rx_sr_q << 1;
            rx_sr_d[0] = s_mosi;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d  = '0;
              word_cnt_d = word_cnt_q + 1'b1;
              rx_word_d  = rx_sr_d;
              rx_index_d = word_cnt_q[IDX_W-1:0];
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (fall) begin
          // bit_cnt==0 on a fall means the rise just before closed a word,
          // so the next status word takes over the shifter.
          if (bit_cnt_q == '0) begin
            tx_sr_d = frame_word(frame_q, word_cnt_q);
          end else begin
            tx_sr_d = tx_sr_q << 1;
          end
          miso_d = tx_sr_d[WORD_BITS-1];
        end
      end

      ST_OVERRUN: begin
        miso_d = 1'b0;
      end

      default: begin
        state_d = ST_ARMWAIT;
      end
    endcase

    // Deselect is judged on the counts after any same-cycle rise.
    if ((state_q == ST_ACTIVE || state_q == ST_OVERRUN) && desel) begin
      good_frame   = (state_d != ST_OVERRUN) && (word_cnt_d == WORD_END) &&
                     (bit_cnt_d == '0);
      frame_done_d = 1'b1;
      frame_ok_d   = good_frame;
      if (!good_frame) begin
        error_count_d = sat_inc(error_count_q);
      end
      miso_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: control/outputs with reset, data shifters without
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_ARMWAIT;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      miso_q        <= 1'b0;
      rx_word_q     <= '0;
      rx_index_q    <= '0;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      miso_q        <= miso_d;
      rx_word_q     <= rx_word_d;
      rx_index_q    <= rx_index_d;
      rx_valid_q    <= rx_valid_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      error_count_q <= error_count_d;
    end
  end

  always_ff @(posedge clock) begin
    frame_q <= frame_d;
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign miso        = miso_q;
  assign rx_word     = rx_word_q;
  assign rx_index    = rx_index_q;
  assign rx_valid    = rx_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_myo_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_myo_spi_slave
//
// Bench for myo_spi_slave: a mode-0 SPI master task drives frames, a monitor
// collects rx_valid/frame_done events, and a frame-level model (expected word
// lists, frame verdict, saturating error counter) supplies expected values.
// -----------------------------------------------------------------------------
module tb_myo_spi_slave;

  localparam int WB   = 16;
  localparam int WPF  = 12;
  localparam int IW   = 4;
  localparam int FW   = WB * WPF;
  localparam int HALF = 5;   // clocks per sck half period (10x oversampling)

  logic          clock = 1'b0;
  logic          reset;
  logic          sck;
  logic          mosi;
  logic          ss_n;
  logic          miso;
  logic [FW-1:0] tx_frame;
  logic [WB-1:0] rx_word;
  logic [IW-1:0] rx_index;
  logic          rx_valid;
  logic          frame_done;
  logic          frame_ok;
  logic [15:0]   error_count;

  always #5 clock = ~clock;

  myo_spi_slave #(
    .WORD_BITS       (WB),
    .WORDS_PER_FRAME (WPF),
    .IDX_W           (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sck         (sck),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .tx_frame    (tx_frame),
    .rx_word     (rx_word),
    .rx_index    (rx_index),
    .rx_valid    (rx_valid),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .error_count (error_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sample outputs on the falling edge.
  logic [IW+WB-1:0] rxq[$];
  int               done_cnt = 0;

  always @(negedge clock) begin
    if (rx_valid)   rxq.push_back({rx_index, rx_word});
    if (frame_done) done_cnt++;
  end

  // Model state
  logic [15:0]   tx_w[WPF];     // status words being prepared
  logic [15:0]   exp_tx[WPF];   // status words the slave captured at select
  logic [FW-1:0] tx_next;       // image applied mid-frame for snapshot test
  logic [15:0]   mw[WPF+2];     // words sent by master
  logic [15:0]   mr[WPF+2];     // words read back by master
  logic [15:0]   exp_err = 16'h0;

  function automatic logic [FW-1:0] pack_tx();
    logic [FW-1:0] p;
    p = '0;
    for (int k = 0; k < WPF; k++) p[(WPF-1-k)*WB +: WB] = tx_w[k];
    return p;
  endfunction

  task automatic capture_tx();
    for (int k = 0; k < WPF; k++) exp_tx[k] = tx_w[k];
  endtask

  task automatic spi_word(input logic [15:0] w, input int nbits,
                          output logic [15:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15-i];
      repeat (HALF) @(negedge clock);
      r   = {r[14:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  // One frame of nw whole words plus nb extra bits; tx_frame switches to
  // tx_next just before word chg_at (negative: never).
  task automatic run_frame(input int nw, input int nb, input int chg_at);
    logic [15:0] r;
    int          np;
    bit          ok;
    rxq.delete();
    done_cnt = 0;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clock);
    for (int w = 0; w < nw; w++) begin
      if (w == chg_at) tx_frame = tx_next;
      spi_word(mw[w], 16, r);
      mr[w] = r;
    end
    if (nb > 0) spi_word(mw[nw], nb, r);
    repeat (HALF) @(negedge clock);
    ss_n = 1'b1;
    repeat (8) @(negedge clock);

    np = (nw < WPF) ? nw : WPF;
    check_eq("rx_count", rxq.size(), np);
    for (int k = 0; k < np && k < rxq.size(); k++) begin
      check_eq($sformatf("rx_word[%0d]", k), {16'h0, rxq[k][WB-1:0]}, {16'h0, mw[k]});
      check_eq($sformatf("rx_index[%0d]", k), {28'h0, rxq[k][IW+WB-1:WB]}, k);
    end
    for (int w = 0; w < nw; w++) begin
      check_eq($sformatf("miso_word[%0d]", w), {16'h0, mr[w]},
               (w < WPF) ? {16'h0, exp_tx[w]} : 32'h0);
    end
    ok = (nw == WPF) && (nb == 0);
    if (!ok && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    check_eq("frame_done_cnt", done_cnt, 1);
    check_eq("frame_ok", {31'h0, frame_ok}, {31'h0, ok});
    check_eq("error_count", {16'h0, error_count}, {16'h0, exp_err});
  endtask

  initial begin
    logic [15:0] r;
    int          nw, nb;

    reset = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    ss_n  = 1'b1;
    for (int k = 0; k < WPF; k++) tx_w[k] = 16'h0;
    tx_frame = pack_tx();
    tx_next  = tx_frame;
    repeat (6) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    check_eq("rst_miso",        {31'h0, miso},        0);
    check_eq("rst_rx_word",     {16'h0, rx_word},     0);
    check_eq("rst_rx_index",    {28'h0, rx_index},    0);
    check_eq("rst_rx_valid",    {31'h0, rx_valid},    0);
    check_eq("rst_frame_done",  {31'h0, frame_done},  0);
    check_eq("rst_frame_ok",    {31'h0, frame_ok},    0);
    check_eq("rst_error_count", {16'h0, error_count}, 0);

    // Nominal frame
    for (int k = 0; k < WPF; k++) begin
      tx_w[k] = 16'hA000 + 16'(k);
      mw[k]   = 16'h1100 + 16'(k);
    end
    tx_frame = pack_tx();
    capture_tx();
    run_frame(WPF, 0, -1);

    // Short frame: 5 words and 7 bits
    mw[5] = 16'h5A5A;
    run_frame(5, 7, -1);

    // Overrun: 13 words
    mw[12] = 16'hCAFE;
    run_frame(13, 0, -1);

    // Zero-length frame
    run_frame(0, 0, -1);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < WPF; k++) tx_w[k] = 16'($urandom);
      for (int k = 0; k < WPF + 2; k++) mw[k] = 16'($urandom);
      tx_frame = pack_tx();
      capture_tx();
      nw = (f == 0) ? WPF : int'($urandom_range(0, 13));
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
      run_frame(nw, nb, -1);
    end

    // Snapshot: tx_frame changes during the frame
    for (int k = 0; k < WPF; k++) tx_w[k] = 16'($urandom);
    tx_w[0] = 16'hBEEF;
    tx_frame = pack_tx();
    capture_tx();
    tx_w[0] = 16'h1234;
    tx_w[5] = tx_w[5] ^ 16'hFFFF;
    tx_next = pack_tx();
    for (int k = 0; k < WPF; k++) mw[k] = 16'($urandom);
    run_frame(WPF, 0, 1);
    check_eq("snap_word0_old", {16'h0, mr[0]}, 32'hBEEF);
    capture_tx();
    run_frame(WPF, 0, -1);
    check_eq("snap_word0_new", {16'h0, mr[0]}, 32'h1234);

    // Reset in the middle of word 3 with ss_n held low
    ss_n = 1'b0;
    repeat (HALF) @(negedge clock);
    for (int w = 0; w < 3; w++) spi_word(mw[w], 16, r);
    spi_word(mw[3], 5, r);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    rxq.delete();
    done_cnt = 0;
    exp_err  = 16'h0;
    spi_word(mw[3], 11, r);
    for (int w = 4; w < WPF; w++) spi_word(mw[w], 16, r);
    repeat (HALF) @(negedge clock);
    ss_n = 1'b1;
    repeat (8) @(negedge clock);
    check_eq("rst_mid_rx_count",  rxq.size(), 0);
    check_eq("rst_mid_done_cnt",  done_cnt, 0);
    check_eq("rst_mid_error_cnt", {16'h0, error_count}, 0);
    run_frame(WPF, 0, -1);

    // Saturation of error_count
    force dut.error_count_q = 16'hFFFE;
    @(posedge clock);
    @(negedge clock);
    release dut.error_count_q;
    @(negedge clock);
    check_eq("sat_preload", {16'h0, error_count}, 32'hFFFE);
    exp_err = 16'hFFFE;
    for (int i = 0; i < 3; i++) run_frame(2, 3, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
